kw11l_ctl: RTL and testbench

Controller for the KW11-L line-clock CSR at iopage offset 13'o17546. Generates the 60 Hz line tick, from an internal prescaler or a synchronised external line input. Maintains the MONITOR and IE bits, and sequences the interrupt request/acknowledge handshake toward the CPU's interrupt arbiter. Sits on the iopage bus beside the other device register blocks.

---
 rtl/kw11l_pkg.sv | 8 +
 rtl/kw11l_tick_gen.sv | 34 +++
 rtl/kw11l_ctl.sv | 51 +++++
 tb/tb_kw11l_ctl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/kw11l_pkg.sv
// kw11l_pkg: shared constants for the KW11-L line-clock controller
package kw11l_pkg;
    localparam logic [12:0] KW11L_CSR_ADDR = 13'o17546;
    localparam logic [7:0]  KW11L_VECTOR   = 8'o100;
    localparam int          KW11L_CLK_DIV  = 833333;
    localparam int          MON_BIT        = 7;
    localparam int          IE_BIT         = 6;
endpackage

// File: rtl/kw11l_tick_gen.sv
// kw11l_tick_gen: line tick from an internal prescaler or a synchronised external input
module kw11l_tick_gen
    import kw11l_pkg::*;
#(
    parameter int CLK_DIV      = KW11L_CLK_DIV,
    parameter bit USE_EXT_TICK = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic line_tick_in,
    output logic tick
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    logic [CW-1:0] cnt;
    logic s1, s2, prev, ext_tick;
    // free-running prescaler plus two-flop synchroniser and registered rising-edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            prev     <= 1'b0;
            ext_tick <= 1'b0;
        end else begin
            cnt      <= (cnt == LAST) ? '0 : cnt + CW'(1);
            s1       <= line_tick_in;
            s2       <= s1;
            prev     <= s2;
            ext_tick <= s2 & ~prev;
        end
    end
    assign tick = USE_EXT_TICK ? ext_tick : (cnt == LAST);
endmodule

// File: rtl/kw11l_ctl.sv
// kw11l_ctl: KW11-L line-clock CSR, bus decode and interrupt sequencing
module kw11l_ctl
    import kw11l_pkg::*;
#(
    parameter int          CLK_DIV      = KW11L_CLK_DIV,
    parameter bit          USE_EXT_TICK = 1'b0,
    parameter logic [7:0]  VECTOR       = KW11L_VECTOR,
    parameter logic [12:0] CSR_ADDR     = KW11L_CSR_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] iopage_addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        decode,
    input  logic        iopage_rd,
    input  logic        iopage_wr,
    input  logic        iopage_byte_op,
    input  logic        line_tick_in,
    output logic        interrupt,
    input  logic        interrupt_ack,
    output logic [7:0]  vector,
    output logic        tick
);
    logic mon, ie, irq_pending, wr, ie_eff, unused_data;
    kw11l_tick_gen #(.CLK_DIV(CLK_DIV), .USE_EXT_TICK(USE_EXT_TICK)) u_tick (
        .clk          (clk),
        .reset        (reset),
        .line_tick_in (line_tick_in),
        .tick         (tick)
    );
    assign decode      = (iopage_addr[12:1] == CSR_ADDR[12:1]);
    assign wr          = decode & iopage_wr & ~(iopage_byte_op & iopage_addr[0]);
    assign ie_eff      = wr ? data_in[IE_BIT] : ie;
    assign unused_data = ^{data_in[15:8], data_in[5:0]};
    // tick sets MONITOR over a clearing write; a new tick request beats a same-cycle ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mon         <= 1'b0;
            ie          <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            mon         <= tick | (mon & ~(wr & ~data_in[MON_BIT]));
            ie          <= ie_eff;
            irq_pending <= (tick & ie_eff) | (irq_pending & ~interrupt_ack & ~(wr & ~data_in[IE_BIT]));
        end
    end
    assign data_out  = (decode & iopage_rd) ? {8'b0, mon, ie, 6'b0} : 16'b0;
    assign interrupt = irq_pending;
    assign vector    = VECTOR;
endmodule

// File: tb/tb_kw11l_ctl.sv
// tb_kw11l_ctl: scoreboard bench for kw11l_ctl, internal and external tick builds
module tb_kw11l_ctl;
    logic        clk = 1'b0, reset = 1'b1;
    logic [12:0] iopage_addr = 13'o17546;
    logic [15:0] data_in = '0;
    logic        iopage_rd = 1'b0, iopage_wr = 1'b0, iopage_byte_op = 1'b0;
    logic        line_tick_in = 1'b0, interrupt_ack = 1'b0;
    logic [15:0] dout_i, dout_x;
    logic        dec_i, dec_x, int_i, int_x, tick_i, tick_x;
    logic [7:0]  vec_i, vec_x;
    logic [15:0] exp_q[$];
    int          n_cmp = 0, n_bad = 0;

    kw11l_ctl #(.CLK_DIV(4), .USE_EXT_TICK(1'b0)) dut_i (
        .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
        .data_out(dout_i), .decode(dec_i), .iopage_rd(iopage_rd), .iopage_wr(iopage_wr),
        .iopage_byte_op(iopage_byte_op), .line_tick_in(1'b0), .interrupt(int_i),
        .interrupt_ack(interrupt_ack), .vector(vec_i), .tick(tick_i)
    );
    kw11l_ctl #(.CLK_DIV(4), .USE_EXT_TICK(1'b1)) dut_x (
        .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
        .data_out(dout_x), .decode(dec_x), .iopage_rd(iopage_rd), .iopage_wr(iopage_wr),
        .iopage_byte_op(iopage_byte_op), .line_tick_in(line_tick_in), .interrupt(int_x),
        .interrupt_ack(interrupt_ack), .vector(vec_x), .tick(tick_x)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [12:0] a, input logic [15:0] d, input logic b);
        iopage_addr = a; data_in = d; iopage_byte_op = b; iopage_wr = 1'b1;
        step();
        iopage_wr = 1'b0; iopage_byte_op = 1'b0; data_in = '0;
    endtask

    task automatic rd(input string tag, input logic [12:0] a, input logic [15:0] e, input bit x);
        iopage_addr = a; iopage_rd = 1'b1;
        exp_q.push_back(e);
        #1;
        check(tag, x ? dout_x : dout_i, exp_q.pop_front());
        iopage_rd = 1'b0;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!tick_i && n < 8) begin
            step();
            n++;
        end
        check("wait_tick", {15'b0, tick_i}, 16'd1);
    endtask

    task automatic ext_window(input string tag, input int exp_cnt, input int exp_first);
        int cnt = 0, first = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (tick_x) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        check({tag, "_cnt"}, 16'(cnt), 16'(exp_cnt));
        check({tag, "_lat"}, 16'(first), 16'(exp_first));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rd("rst_csr", 13'o17546, 16'o0, 0);
        check("rst_int", {15'b0, int_i}, 16'd0);
        for (int c = 0; c < 12; c++) begin
            check($sformatf("tick_c%0d", c), {15'b0, tick_i}, {15'b0, (c % 4) == 3});
            check($sformatf("noirq_c%0d", c), {15'b0, int_i}, 16'd0);
            step();
        end
        rd("mon_set", 13'o17546, 16'o200, 0);

        wr(13'o17546, 16'o100, 1'b0);
        wait_tick();
        check("int_at_tick", {15'b0, int_i}, 16'd0);
        step();
        check("int_after_tick", {15'b0, int_i}, 16'd1);
        check("vector", {8'b0, vec_i}, 16'o100);
        ack();
        check("int_acked", {15'b0, int_i}, 16'd0);
        rd("csr_300", 13'o17546, 16'o300, 0);

        wait_tick();
        wr(13'o17546, 16'o0, 1'b0);
        rd("mon_set_wins", 13'o17546, 16'o200, 0);
        check("no_irq_ie0", {15'b0, int_i}, 16'd0);
        wr(13'o17546, 16'o100, 1'b0);
        wait_tick();
        step();
        check("irq_again", {15'b0, int_i}, 16'd1);
        wr(13'o17546, 16'o0, 1'b0);
        check("ie0_clears", {15'b0, int_i}, 16'd0);
        rd("csr_cleared", 13'o17546, 16'o0, 0);

        wr(13'o17546, 16'o100, 1'b0);
        wait_tick();
        step();
        check("irq_t4", {15'b0, int_i}, 16'd1);
        wait_tick();
        ack();
        check("tick_beats_ack", {15'b0, int_i}, 16'd1);
        ack();
        check("second_ack", {15'b0, int_i}, 16'd0);

        wait_tick();
        step();
        wr(13'o17546, 16'o0, 1'b0);
        wr(13'o17547, 16'o300, 1'b1);
        rd("odd_byte_ign", 13'o17546, 16'o0, 0);
        rd("odd_read", 13'o17547, 16'o0, 0);
        wr(13'o17546, 16'o100, 1'b1);
        rd("even_byte", 13'o17546, 16'o100, 0);
        iopage_addr = 13'o17546; #1 check("dec_even", {15'b0, dec_i}, 16'd1);
        iopage_addr = 13'o17547; #1 check("dec_odd", {15'b0, dec_i}, 16'd1);
        iopage_addr = 13'o17544; #1 check("dec_miss", {15'b0, dec_i}, 16'd0);
        rd("miss_read", 13'o17544, 16'o0, 0);

        step();
        rd("ext_pre", 13'o17546, 16'o100, 1);
        #2 line_tick_in = 1'b1;
        ext_window("ext_rise1", 1, 3);
        check("ext_irq", {15'b0, int_x}, 16'd1);
        check("ext_vec", {8'b0, vec_x}, 16'o100);
        rd("ext_mon", 13'o17546, 16'o300, 1);
        #3 line_tick_in = 1'b0;
        ext_window("ext_fall", 0, 0);
        #4 line_tick_in = 1'b1;
        ext_window("ext_rise2", 1, 3);

        #2 reset = 1'b1;
        #1;
        check("rst_drop_x", {15'b0, int_x}, 16'd0);
        rd("rst_csr_x", 13'o17546, 16'o0, 1);
        rd("rst_csr_i", 13'o17546, 16'o0, 0);
        step();
        reset = 1'b0;
        check("rst_tick_x", {15'b0, tick_x}, 16'd0);
        rd("post_rst_x", 13'o17546, 16'o0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
